// File: rtl/bridge_router_pkg.sv
// Shared types and helpers for the host bridge router: address windows, read-pipe stage, byte swap.
package bridge_router_pkg;

    localparam int MAX_LEAVES     = 16;
    localparam int MAX_RD_LATENCY = 8;

    typedef struct packed {
        logic [31:0] from_addr;
        logic [31:0] to_addr;
    } bridge_addr_range_t;

    typedef struct packed {
        logic        valid;
        logic        miss;
        logic [3:0]  idx;
        logic [31:0] data;
        logic        done;
    } bridge_router_stage_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/bridge_router_if.sv
// Host side of the APF bridge as seen by the router: one-cycle wr/rd strobes and registered read data.
interface bridge_router_if;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wr_data;
    logic        rd;
    logic [31:0] rd_data;

    modport master (output addr, wr, wr_data, rd, input rd_data);
    modport slave  (input addr, wr, wr_data, rd, output rd_data);
endinterface

// File: rtl/bridge_addr_decode.sv
// Combinational window compare with lowest-index priority; also yields the window-relative address.
module bridge_addr_decode
    import bridge_router_pkg::*;
#(
    parameter int                 NUM_LEAVES = 6,
    parameter bridge_addr_range_t ADDR_RANGES [NUM_LEAVES] = '{default: '0}
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [3:0]  idx,
    output logic [31:0] rel_addr
);

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        rel_addr = addr;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if (addr >= ADDR_RANGES[i].from_addr && addr <= ADDR_RANGES[i].to_addr) begin
                hit      = 1'b1;
                idx      = i[3:0];
                rel_addr = addr - ADDR_RANGES[i].from_addr;
            end
        end
    end

endmodule

// File: rtl/bridge_router.sv
// Splits the host APF bridge into NUM_LEAVES address windows with registered leaf strobes,
// per-leaf read latency realigned to a fixed host latency, per-leaf endianness and miss tracking.
module bridge_router
    import bridge_router_pkg::*;
#(
    parameter int                    NUM_LEAVES = 6,
    parameter bridge_addr_range_t    ADDR_RANGES [NUM_LEAVES] = '{default: '0},
    parameter int                    LEAF_LATENCY [NUM_LEAVES] = '{default: 1},
    parameter int                    RD_LATENCY = 4,
    parameter logic [NUM_LEAVES-1:0] LITTLE_MASK = '0,
    parameter logic [NUM_LEAVES-1:0] RELATIVE_MASK = '0,
    parameter logic [31:0]           MISS_RD_DATA = 32'hDEAD_BEEF
) (
    input  logic                         clk_74a,
    input  logic                         reset_n,
    bridge_router_if.slave               host,
    output logic [NUM_LEAVES-1:0][31:0]  leaf_addr,
    output logic [NUM_LEAVES-1:0]        leaf_wr,
    output logic [NUM_LEAVES-1:0][31:0]  leaf_wr_data,
    output logic [NUM_LEAVES-1:0]        leaf_rd,
    input  logic [NUM_LEAVES-1:0][31:0]  leaf_rd_data,
    output logic [15:0]                  miss_count,
    output logic [31:0]                  miss_addr
);

    if (NUM_LEAVES < 1 || NUM_LEAVES > MAX_LEAVES) begin : g_bad_leaves
        $error("bridge_router: NUM_LEAVES out of range");
    end
    if (RD_LATENCY < 2 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_rd_lat
        $error("bridge_router: RD_LATENCY out of range");
    end
    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_leaf_chk
        if (LEAF_LATENCY[g] < 1 || LEAF_LATENCY[g] >= RD_LATENCY) begin : g_bad_leaf_lat
            $error("bridge_router: LEAF_LATENCY must be 1..RD_LATENCY-1");
        end
        if (ADDR_RANGES[g].from_addr > ADDR_RANGES[g].to_addr) begin : g_bad_range
            $error("bridge_router: window from_addr above to_addr");
        end
    end

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    logic        hit;
    logic [3:0]  hit_idx;
    logic [31:0] rel_addr;

    bridge_addr_decode #(
        .NUM_LEAVES  (NUM_LEAVES),
        .ADDR_RANGES (ADDR_RANGES)
    ) u_decode (
        .addr     (host.addr),
        .hit      (hit),
        .idx      (hit_idx),
        .rel_addr (rel_addr)
    );

    logic wr_req, rd_req, access, miss;

    // A write in the same cycle as a read wins; the read vanishes without counting as a miss.
    assign wr_req = host.wr;
    assign rd_req = host.rd & ~host.wr;
    assign access = wr_req | rd_req;
    assign miss   = access & ~hit;

    always_ff @(posedge clk_74a or negedge rst_int_n) begin
        if (!rst_int_n) begin
            leaf_addr    <= '0;
            leaf_wr_data <= '0;
            leaf_wr      <= '0;
            leaf_rd      <= '0;
            miss_count   <= '0;
            miss_addr    <= '0;
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                leaf_wr[i] <= 1'b0;
                leaf_rd[i] <= 1'b0;
                if (access && hit && int'(hit_idx) == i) begin
                    leaf_addr[i]    <= RELATIVE_MASK[i] ? rel_addr : host.addr;
                    leaf_wr_data[i] <= LITTLE_MASK[i] ? byte_swap32(host.wr_data) : host.wr_data;
                    leaf_wr[i]      <= wr_req;
                    leaf_rd[i]      <= rd_req;
                end
            end
            if (miss) begin
                miss_addr <= host.addr;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end

    // stg[k] holds an entry k edges after its strobe; the last hop lands in host.rd_data,
    // so host.rd_data itself plays the role of stage RD_LATENCY.
    bridge_router_stage_t stg [1:RD_LATENCY-1];
    bridge_router_stage_t adv [2:RD_LATENCY];
    bridge_router_stage_t entry_in;

    always_comb begin
        entry_in       = '0;
        entry_in.valid = rd_req;
        entry_in.miss  = ~hit;
        entry_in.idx   = hit_idx;
        entry_in.data  = hit ? 32'h0 : MISS_RD_DATA;
        entry_in.done  = ~hit;
        if (!rd_req) entry_in = '0;
    end

    // Entering stage k = 1 + LEAF_LATENCY samples that leaf's data from the current cycle.
    always_comb begin
        for (int k = 2; k <= RD_LATENCY; k++) begin
            adv[k] = stg[k-1];
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (stg[k-1].valid && !stg[k-1].miss && !stg[k-1].done &&
                    int'(stg[k-1].idx) == i && LEAF_LATENCY[i] == k - 1) begin
                    adv[k].data = LITTLE_MASK[i] ? byte_swap32(leaf_rd_data[i]) : leaf_rd_data[i];
                    adv[k].done = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_74a or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int k = 1; k < RD_LATENCY; k++) stg[k] <= '0;
            host.rd_data <= '0;
        end else begin
            stg[1] <= entry_in;
            for (int k = 2; k < RD_LATENCY; k++) stg[k] <= adv[k];
            if (adv[RD_LATENCY].valid) host.rd_data <= adv[RD_LATENCY].data;
        end
    end

endmodule

// File: tb/tb_bridge_router.sv
// Directed bench for bridge_router: writes, endianness, relative addressing, mixed-latency reads,
// misses with saturation, overlap priority, wr/rd collision and mid-read reset.
module tb_bridge_router;
    import bridge_router_pkg::*;

    localparam int N = 6;

    logic clk_74a = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_74a = ~clk_74a;

    bridge_router_if host ();

    logic [N-1:0][31:0] leaf_addr;
    logic [N-1:0]       leaf_wr;
    logic [N-1:0][31:0] leaf_wr_data;
    logic [N-1:0]       leaf_rd;
    logic [N-1:0][31:0] leaf_rd_data;
    logic [15:0]        miss_count;
    logic [31:0]        miss_addr;

    int checks = 0;
    int errors = 0;

    bridge_router #(
        .NUM_LEAVES    (N),
        .ADDR_RANGES   ('{'{32'hF800_0000, 32'hF800_00FF},
                          '{32'h0010_0000, 32'h0010_00FF},
                          '{32'h0010_0080, 32'h0010_01FF},
                          '{32'h0020_0000, 32'h0020_00FF},
                          '{32'h0040_0000, 32'h0040_00FF},
                          '{32'h1000_0000, 32'h1000_FFFF}}),
        .LEAF_LATENCY  ('{1, 3, 2, 2, 3, 1}),
        .RD_LATENCY    (4),
        .LITTLE_MASK   (6'b100010),
        .RELATIVE_MASK (6'b011000),
        .MISS_RD_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .host         (host),
        .leaf_addr    (leaf_addr),
        .leaf_wr      (leaf_wr),
        .leaf_wr_data (leaf_wr_data),
        .leaf_rd      (leaf_rd),
        .leaf_rd_data (leaf_rd_data),
        .miss_count   (miss_count),
        .miss_addr    (miss_addr)
    );

    // Leaf model: data is valid only in the one cycle the router should sample it
    // (latency 1 = same cycle as leaf_rd, each extra cycle one more register).
    localparam logic [N-1:0][31:0] RESP = {32'h5555_0005, 32'h4444_0004, 32'h3333_0003,
                                           32'h2222_0002, 32'hA1B2_C3D4, 32'h1111_0001};
    logic [N-1:0] rd_d1 = '0, rd_d2 = '0, rd_valid;
    always @(posedge clk_74a) begin
        rd_d1 <= leaf_rd;
        rd_d2 <= rd_d1;
    end
    always_comb begin
        rd_valid = {leaf_rd[5], rd_d2[4], rd_d1[3], rd_d1[2], rd_d2[1], leaf_rd[0]};
        for (int i = 0; i < N; i++)
            leaf_rd_data[i] = rd_valid[i] ? RESP[i] : (32'hBAD0_0000 | 32'(i));
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_74a);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        host.addr = '0; host.wr = 1'b0; host.wr_data = '0; host.rd = 1'b0;
    endtask

    initial begin
        idle();
        step(3);
        reset_n = 1'b1;
        step(4);

        // Reset state
        chk("rst_leaf_wr", 32'(leaf_wr), 32'h0);
        chk("rst_leaf_rd", 32'(leaf_rd), 32'h0);
        chk("rst_leaf_addr0", leaf_addr[0], 32'h0);
        chk("rst_leaf_wdata5", leaf_wr_data[5], 32'h0);
        chk("rst_rd_data", host.rd_data, 32'h0);
        chk("rst_miss_count", 32'(miss_count), 32'h0);
        chk("rst_miss_addr", miss_addr, 32'h0);

        // Big-endian absolute write to leaf0
        host.addr = 32'hF800_0010; host.wr_data = 32'h1122_3344; host.wr = 1'b1;
        step(); idle();
        chk("wr0_strobe", 32'(leaf_wr), 32'h01);
        chk("wr0_data", leaf_wr_data[0], 32'h1122_3344);
        chk("wr0_addr", leaf_addr[0], 32'hF800_0010);
        step();
        chk("wr0_pulse_end", 32'(leaf_wr), 32'h0);
        chk("wr0_data_held", leaf_wr_data[0], 32'h1122_3344);

        // Little-endian leaf5
        host.addr = 32'h1000_0020; host.wr_data = 32'h1122_3344; host.wr = 1'b1;
        step(); idle();
        chk("wr5_strobe", 32'(leaf_wr), 32'h20);
        chk("wr5_data_swap", leaf_wr_data[5], 32'h4433_2211);
        chk("wr5_addr", leaf_addr[5], 32'h1000_0020);
        chk("wr5_leaf0_kept", leaf_addr[0], 32'hF800_0010);

        // Relative leaf3
        host.addr = 32'h0020_0008; host.wr_data = 32'hCAFE_F00D; host.wr = 1'b1;
        step(); idle();
        chk("wr3_rel_addr", leaf_addr[3], 32'h0000_0008);
        chk("wr3_data", leaf_wr_data[3], 32'hCAFE_F00D);
        step();

        // Back-to-back reads: leaf0 (lat 1), leaf4 (lat 3, relative), leaf2 (lat 2)
        host.addr = 32'hF800_0004; host.rd = 1'b1;
        step();
        chk("bb_rd_strobe0", 32'(leaf_rd), 32'h01);
        host.addr = 32'h0040_0010;
        step();
        chk("bb_rd_strobe4", 32'(leaf_rd), 32'h10);
        chk("bb_rel_addr4", leaf_addr[4], 32'h0000_0010);
        host.addr = 32'h0010_0100;
        step(); idle();
        chk("bb_rd_strobe2", 32'(leaf_rd), 32'h04);
        chk("bb_not_yet", host.rd_data, 32'h0);
        step();
        chk("bb_data_a", host.rd_data, 32'h1111_0001);
        step();
        chk("bb_data_b", host.rd_data, 32'h4444_0004);
        step();
        chk("bb_data_c", host.rd_data, 32'h2222_0002);
        step(2);
        chk("bb_data_c_held", host.rd_data, 32'h2222_0002);

        // Unmapped read
        host.addr = 32'h3000_0000; host.rd = 1'b1;
        step(); idle();
        chk("miss_no_rd", 32'(leaf_rd), 32'h0);
        chk("miss_no_wr", 32'(leaf_wr), 32'h0);
        chk("miss_count1", 32'(miss_count), 32'h1);
        chk("miss_addr1", miss_addr, 32'h3000_0000);
        step(3);
        chk("miss_rd_data", host.rd_data, 32'hDEAD_BEEF);

        // Overlap: leaf1 and leaf2 both hit, leaf1 (little) wins
        host.addr = 32'h0010_0090; host.wr_data = 32'h5566_7788; host.wr = 1'b1;
        step(); idle();
        chk("ovl_strobe", 32'(leaf_wr), 32'h02);
        chk("ovl_data1", leaf_wr_data[1], 32'h8877_6655);
        chk("ovl_addr1", leaf_addr[1], 32'h0010_0090);

        // Write and read together: write only, read dropped
        host.addr = 32'hF800_0020; host.wr_data = 32'h0A0B_0C0D; host.wr = 1'b1; host.rd = 1'b1;
        step(); idle();
        chk("wrrd_wr", 32'(leaf_wr), 32'h01);
        chk("wrrd_rd", 32'(leaf_rd), 32'h0);
        step(4);
        chk("wrrd_no_rd_data", host.rd_data, 32'hDEAD_BEEF);
        chk("wrrd_no_miss", 32'(miss_count), 32'h1);

        // Little-endian read from leaf1 (lat 3)
        host.addr = 32'h0010_0010; host.rd = 1'b1;
        step(); idle();
        step(3);
        chk("rd1_swap", host.rd_data, 32'hD4C3_B2A1);

        // Reset one cycle after a read
        host.addr = 32'hF800_0008; host.rd = 1'b1;
        step(); idle();
        reset_n = 1'b0;
        #1;
        chk("rstmid_rd_data", host.rd_data, 32'h0);
        chk("rstmid_miss_count", 32'(miss_count), 32'h0);
        step();
        reset_n = 1'b1;
        step(5);
        chk("rstmid_no_update", host.rd_data, 32'h0);
        host.addr = 32'hF800_0008; host.rd = 1'b1;
        step(); idle();
        step(2);
        chk("rstmid_next_early", host.rd_data, 32'h0);
        step();
        chk("rstmid_next_read", host.rd_data, 32'h1111_0001);

        // Miss counting and saturation
        host.addr = 32'h3000_0100; host.wr_data = 32'h0; host.wr = 1'b1;
        step(10);
        chk("sat_count10", 32'(miss_count), 32'd10);
        chk("sat_addr", miss_addr, 32'h3000_0100);
        chk("sat_no_strobe", 32'(leaf_wr), 32'h0);
        host.addr = 32'h7FFF_0000;
        step(65524);
        chk("sat_fffe", 32'(miss_count), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(miss_count), 32'hFFFF);
        step(5);
        idle();
        chk("sat_stays", 32'(miss_count), 32'hFFFF);
        chk("sat_addr_last", miss_addr, 32'h7FFF_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
